// File: rtl/oled_pixel_streamer_pkg.sv
// Shared constants for the SSD1331 PmodOLED streamer: panel geometry, power-up
// command list and the top-level sequencing states.
package oled_pkg;

  localparam int WIDTH      = 96;
  localparam int HEIGHT     = 64;
  localparam int NUM_PIXELS = WIDTH * HEIGHT;
  localparam int INIT_LEN   = 10;

  localparam logic [7:0] INIT_ROM [INIT_LEN] = '{
    8'hAE, 8'hA0, 8'h72, 8'h15, 8'h00, 8'h5F, 8'h75, 8'h00, 8'h3F, 8'hAF
  };

  typedef enum logic [2:0] {
    ST_PWR_RST,
    ST_PWR_WAIT,
    ST_VCC_WAIT,
    ST_INIT,
    ST_FRAME,
    ST_FETCH,
    ST_SEND_HI,
    ST_SEND_LO
  } state_t;

  function automatic logic [7:0] init_byte(input logic [3:0] idx);
    return (int'(idx) < INIT_LEN) ? INIT_ROM[idx] : 8'h00;
  endfunction

endpackage

// File: rtl/oled_pixel_streamer_spi_byte_tx.sv
// SPI byte serialiser: MSB first, sclk idles high, 16 cycles with cs low plus
// one cs-high gap cycle. A new start is accepted while idle or in the gap.
module spi_byte_tx (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic       dc,
  output logic       busy,
  output logic       done,
  output logic       cs,
  output logic       sclk,
  output logic       sdin,
  output logic       d_cn
);

  localparam logic [4:0] GAP = 5'd16;

  logic       active;
  logic [4:0] phase;
  logic [4:0] phase_nx;
  logic [7:0] shreg;

  assign phase_nx = phase + 5'd1;
  assign busy     = active;
  assign done     = active && (phase == GAP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active <= 1'b0;
      phase  <= '0;
      shreg  <= '0;
      cs     <= 1'b1;
      sclk   <= 1'b1;
      sdin   <= 1'b0;
      d_cn   <= 1'b0;
    end else if (start && (!active || phase == GAP)) begin
      active <= 1'b1;
      phase  <= '0;
      shreg  <= {tx_byte[6:0], 1'b0};
      cs     <= 1'b0;
      sclk   <= 1'b0;
      sdin   <= tx_byte[7];
      d_cn   <= dc;
    end else if (active) begin
      if (phase == GAP) begin
        active <= 1'b0;
      end else begin
        phase <= phase_nx;
        // even phases present a new bit with sclk low, odd phases raise sclk
        if (phase_nx == GAP) begin
          cs   <= 1'b1;
          sclk <= 1'b1;
        end else if (phase_nx[0]) begin
          sclk <= 1'b1;
        end else begin
          sclk  <= 1'b0;
          sdin  <= shreg[7];
          shreg <= {shreg[6:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: rtl/oled_pixel_streamer.sv
// SSD1331 display-side streamer: power sequencing, init command list, then a
// continuous raster scan requesting RGB565 pixels and shifting them out over SPI.
module oled_pixel_streamer
  import oled_pkg::*;
#(
  parameter int RST_CYCLES   = 20,
  parameter int VCC_CYCLES   = 625000,
  parameter int FRAME_PIXELS = oled_pkg::NUM_PIXELS
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [15:0] pixel_data,
  output logic [12:0] pixel_index,
  output logic        sample_pixel,
  output logic        frame_begin,
  output logic        sending_pixels,
  output logic        cs,
  output logic        sdin,
  output logic        sclk,
  output logic        d_cn,
  output logic        resn,
  output logic        vccen,
  output logic        pmoden
);

  localparam logic [12:0] LAST_INDEX = 13'(FRAME_PIXELS - 1);

  state_t      state;
  logic [19:0] cnt;
  logic [3:0]  init_idx;
  logic        fetch_wait;
  logic [7:0]  lo_latch;

  logic        tx_start;
  logic [7:0]  tx_byte;
  logic        tx_dc;
  logic        tx_busy;
  logic        tx_done;

  // The high byte launches on the same edge pixel_data is captured, so it is
  // taken straight from the input; only the low byte needs holding.
  always_comb begin
    tx_start = 1'b0;
    tx_byte  = 8'h00;
    tx_dc    = 1'b0;
    case (state)
      ST_VCC_WAIT: begin
        tx_start = (cnt == '0) && !tx_busy;
        tx_byte  = init_byte(4'd0);
      end
      ST_INIT: begin
        tx_start = tx_done && (init_idx < 4'(INIT_LEN));
        tx_byte  = init_byte(init_idx);
      end
      ST_FETCH: begin
        tx_start = fetch_wait;
        tx_byte  = pixel_data[15:8];
        tx_dc    = 1'b1;
      end
      ST_SEND_HI: begin
        tx_start = tx_done;
        tx_byte  = lo_latch;
        tx_dc    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state          <= ST_PWR_RST;
      cnt            <= 20'(RST_CYCLES);
      init_idx       <= '0;
      fetch_wait     <= 1'b0;
      lo_latch       <= '0;
      pixel_index    <= '0;
      sample_pixel   <= 1'b0;
      frame_begin    <= 1'b0;
      sending_pixels <= 1'b0;
      resn           <= 1'b0;
      vccen          <= 1'b0;
      pmoden         <= 1'b0;
    end else begin
      pmoden       <= 1'b1;
      sample_pixel <= 1'b0;
      frame_begin  <= 1'b0;
      case (state)
        ST_PWR_RST: begin
          if (cnt == '0) begin
            resn  <= 1'b1;
            cnt   <= 20'(VCC_CYCLES - 1);
            state <= ST_PWR_WAIT;
          end else begin
            cnt <= cnt - 20'd1;
          end
        end
        ST_PWR_WAIT: begin
          if (cnt == '0) begin
            vccen <= 1'b1;
            cnt   <= 20'(VCC_CYCLES - 1);
            state <= ST_VCC_WAIT;
          end else begin
            cnt <= cnt - 20'd1;
          end
        end
        ST_VCC_WAIT: begin
          // first init byte is launched on this same edge by tx_start
          if (cnt == '0) begin
            init_idx <= 4'd1;
            state    <= ST_INIT;
          end else begin
            cnt <= cnt - 20'd1;
          end
        end
        ST_INIT: begin
          if (tx_done) begin
            if (init_idx == 4'(INIT_LEN)) begin
              state          <= ST_FRAME;
              pixel_index    <= '0;
              frame_begin    <= 1'b1;
              sending_pixels <= 1'b0;
            end else begin
              init_idx <= init_idx + 4'd1;
            end
          end
        end
        ST_FRAME: begin
          state          <= ST_FETCH;
          sample_pixel   <= 1'b1;
          sending_pixels <= 1'b1;
          fetch_wait     <= 1'b0;
        end
        ST_FETCH: begin
          if (!fetch_wait) begin
            fetch_wait <= 1'b1;
          end else begin
            lo_latch <= pixel_data[7:0];
            state    <= ST_SEND_HI;
          end
        end
        ST_SEND_HI: begin
          if (tx_done) state <= ST_SEND_LO;
        end
        ST_SEND_LO: begin
          if (tx_done) begin
            if (pixel_index == LAST_INDEX) begin
              state          <= ST_FRAME;
              pixel_index    <= '0;
              frame_begin    <= 1'b1;
              sending_pixels <= 1'b0;
            end else begin
              state        <= ST_FETCH;
              pixel_index  <= pixel_index + 13'd1;
              sample_pixel <= 1'b1;
              fetch_wait   <= 1'b0;
            end
          end
        end
        default: state <= ST_PWR_RST;
      endcase
    end
  end

  spi_byte_tx u_tx (
    .clk     (CLK),
    .rst     (reset),
    .start   (tx_start),
    .tx_byte (tx_byte),
    .dc      (tx_dc),
    .busy    (tx_busy),
    .done    (tx_done),
    .cs      (cs),
    .sclk    (sclk),
    .sdin    (sdin),
    .d_cn    (d_cn)
  );

endmodule

// File: tb/tb_oled_pixel_streamer.sv
// Bench for oled_pixel_streamer: decodes the SPI pins back into bytes and checks
// power timing, init list, pixel streams from several sources and reset behaviour.
module tb_oled_pixel_streamer;

  localparam int RST_C        = 4;
  localparam int VCC_C        = 10;
  localparam int NPIX         = 24;
  localparam int PIX_PERIOD   = 36;
  localparam int FRAME_PERIOD = 1 + NPIX * PIX_PERIOD;
  localparam int BYTE_CYCLES  = 17;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] pixel_data = 16'h0000;
  logic [12:0] pixel_index;
  logic        sample_pixel, frame_begin, sending_pixels;
  logic        cs, sdin, sclk, d_cn, resn, vccen, pmoden;

  logic [7:0]  init_list [10] = '{8'hAE, 8'hA0, 8'h72, 8'h15, 8'h00,
                                  8'h5F, 8'h75, 8'h00, 8'h3F, 8'hAF};

  int checks = 0;
  int errors = 0;
  int mode = 0;
  logic [15:0] rand_lut [NPIX];

  always #5 CLK = ~CLK;

  oled_pixel_streamer #(
    .RST_CYCLES   (RST_C),
    .VCC_CYCLES   (VCC_C),
    .FRAME_PIXELS (NPIX)
  ) dut (
    .CLK            (CLK),
    .reset          (reset),
    .pixel_data     (pixel_data),
    .pixel_index    (pixel_index),
    .sample_pixel   (sample_pixel),
    .frame_begin    (frame_begin),
    .sending_pixels (sending_pixels),
    .cs             (cs),
    .sdin           (sdin),
    .sclk           (sclk),
    .d_cn           (d_cn),
    .resn           (resn),
    .vccen          (vccen),
    .pmoden         (pmoden)
  );

  // pixel generator: one registered stage after pixel_index
  always @(posedge CLK) begin
    case (mode)
      1:       pixel_data <= rand_lut[int'(pixel_index) % NPIX];
      2:       pixel_data <= 16'hF800;
      default: pixel_data <= {3'b000, pixel_index};
    endcase
  end

  // pin-level observer
  int cyc = 0;
  logic p_sclk = 1'b1, p_cs = 1'b1, p_sdin = 1'b0;
  int bitcnt = 0, run = 0, bad_runs = 0, sdin_viol = 0, max_idx = 0, low_run = 0;
  bit seen_send = 0;
  logic [7:0] sh = 8'h00;
  logic [8:0] byte_q [$];
  int sp_cyc_q [$];
  int sp_idx_q [$];
  int fb_q [$];
  int low_q [$];

  always @(negedge CLK) begin
    cyc++;
    if (reset) begin
      bitcnt = 0; run = 0; seen_send = 0; low_run = 0;
    end else begin
      if (!cs && !p_sclk && sclk) begin
        sh = {sh[6:0], sdin};
        bitcnt++;
        if (bitcnt == 8) begin
          byte_q.push_back({d_cn, sh});
          bitcnt = 0;
        end
      end
      if (cs) bitcnt = 0;
      if (!cs) run++;
      else if (!p_cs) begin
        if (run != 16) bad_runs++;
        run = 0;
      end
      if (sdin !== p_sdin && sclk !== 1'b0) sdin_viol++;
      if (sample_pixel) begin
        sp_cyc_q.push_back(cyc);
        sp_idx_q.push_back(int'(pixel_index));
      end
      if (frame_begin) fb_q.push_back(cyc);
      if (int'(pixel_index) > max_idx) max_idx = int'(pixel_index);
      if (sending_pixels) begin
        if (seen_send && low_run > 0) low_q.push_back(low_run);
        seen_send = 1;
        low_run = 0;
      end else if (seen_send) begin
        low_run++;
      end
    end
    p_sclk = sclk; p_cs = cs; p_sdin = sdin;
  end

  task automatic wait_bytes(input int n, input int budget);
    for (int i = 0; i < budget && byte_q.size() < n; i++) @(negedge CLK);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge CLK);
    checks++;
    if ({cs, sclk, sdin, d_cn, resn, vccen, pmoden, frame_begin, sending_pixels, sample_pixel}
        !== 10'b1100000000) begin
      errors++;
      $display("FAIL reset_pins got %b exp 1100000000",
               {cs, sclk, sdin, d_cn, resn, vccen, pmoden, frame_begin, sending_pixels, sample_pixel});
    end
    checks++;
    if (pixel_index !== 13'd0) begin
      errors++;
      $display("FAIL reset_index got %0d exp 0", pixel_index);
    end
  endtask

  task automatic test_power_seq();
    int t_pm, t_resn, t_vcc, t_cs;
    t_pm = -1; t_resn = -1; t_vcc = -1; t_cs = -1;
    @(negedge CLK);
    reset = 1'b0;
    for (int n = 1; n <= 400 && t_cs < 0; n++) begin
      @(negedge CLK);
      if (pmoden === 1'b1 && t_pm < 0) t_pm = n;
      if (resn === 1'b1 && t_resn < 0) t_resn = n;
      if (vccen === 1'b1 && t_vcc < 0) t_vcc = n;
      if (cs === 1'b0 && t_cs < 0) t_cs = n;
    end
    checks++;
    if (t_pm != 1) begin errors++; $display("FAIL pmoden_rise got %0d exp 1", t_pm); end
    checks++;
    if (t_resn != 1 + RST_C) begin
      errors++; $display("FAIL resn_rise got %0d exp %0d", t_resn, 1 + RST_C);
    end
    checks++;
    if (t_vcc != 1 + RST_C + VCC_C) begin
      errors++; $display("FAIL vccen_rise got %0d exp %0d", t_vcc, 1 + RST_C + VCC_C);
    end
    checks++;
    if (t_cs != 1 + RST_C + 2 * VCC_C) begin
      errors++; $display("FAIL first_cs_fall got %0d exp %0d", t_cs, 1 + RST_C + 2 * VCC_C);
    end
  endtask

  // called right at the sample where cs first fell
  task automatic test_init();
    int t_fb;
    logic [8:0] got;
    byte_q.delete();
    t_fb = -1;
    for (int n = 1; n <= 400 && t_fb < 0; n++) begin
      @(negedge CLK);
      if (frame_begin === 1'b1) t_fb = n;
    end
    checks++;
    if (t_fb != 10 * BYTE_CYCLES) begin
      errors++; $display("FAIL init_length got %0d exp %0d", t_fb, 10 * BYTE_CYCLES);
    end
    checks++;
    if (byte_q.size() < 10) begin
      errors++; $display("FAIL init_count got %0d exp 10", byte_q.size());
    end
    for (int i = 0; i < 10; i++) begin
      got = (byte_q.size() > 0) ? byte_q.pop_front() : 9'h1FF;
      checks++;
      if (got !== {1'b0, init_list[i]}) begin
        errors++; $display("FAIL init_byte%0d got %h exp %h", i, got, {1'b0, init_list[i]});
      end
    end
  endtask

  task automatic check_frame_bytes(input string tag);
    logic [15:0] exp;
    logic [8:0] got;
    wait_bytes(2 * NPIX, FRAME_PERIOD + 100);
    checks++;
    if (byte_q.size() < 2 * NPIX) begin
      errors++; $display("FAIL %s_count got %0d exp %0d", tag, byte_q.size(), 2 * NPIX);
    end
    for (int i = 0; i < NPIX; i++) begin
      case (mode)
        1:       exp = rand_lut[i];
        2:       exp = 16'hF800;
        default: exp = 16'(i);
      endcase
      for (int b = 0; b < 2; b++) begin
        got = (byte_q.size() > 0) ? byte_q.pop_front() : 9'h000;
        checks++;
        if (got !== {1'b1, (b == 0) ? exp[15:8] : exp[7:0]}) begin
          errors++;
          $display("FAIL %s_px%0d_b%0d got %h exp %h", tag, i, b, got,
                   {1'b1, (b == 0) ? exp[15:8] : exp[7:0]});
        end
      end
    end
  endtask

  task automatic test_ramp();
    check_frame_bytes("ramp");
    for (int i = 1; i < NPIX; i++) begin
      checks++;
      if (sp_idx_q.size() <= i || sp_idx_q[i] != i || sp_cyc_q[i] - sp_cyc_q[i-1] != PIX_PERIOD) begin
        errors++;
        $display("FAIL sample_spacing%0d got idx %0d gap %0d exp idx %0d gap %0d", i,
                 (sp_idx_q.size() > i) ? sp_idx_q[i] : -1,
                 (sp_cyc_q.size() > i) ? sp_cyc_q[i] - sp_cyc_q[i-1] : -1, i, PIX_PERIOD);
      end
    end
  endtask

  task automatic test_frame_wrap();
    for (int i = 0; i < FRAME_PERIOD + 50 && fb_q.size() < 2; i++) @(negedge CLK);
    repeat (3) @(negedge CLK);
    checks++;
    if (fb_q.size() < 2 || fb_q[1] - fb_q[0] != FRAME_PERIOD) begin
      errors++;
      $display("FAIL frame_period got %0d exp %0d", (fb_q.size() > 1) ? fb_q[1] - fb_q[0] : -1,
               FRAME_PERIOD);
    end
    checks++;
    if (low_q.size() < 1 || low_q[0] != 1) begin
      errors++;
      $display("FAIL sending_low got %0d exp 1", (low_q.size() > 0) ? low_q[0] : -1);
    end
    checks++;
    if (max_idx != NPIX - 1) begin
      errors++; $display("FAIL max_index got %0d exp %0d", max_idx, NPIX - 1);
    end
    checks++;
    if (sp_idx_q.size() <= NPIX || sp_idx_q[NPIX] != 0 ||
        sp_cyc_q[NPIX] - sp_cyc_q[NPIX-1] != PIX_PERIOD + 1) begin
      errors++;
      $display("FAIL index_wrap got idx %0d gap %0d exp idx 0 gap %0d",
               (sp_idx_q.size() > NPIX) ? sp_idx_q[NPIX] : -1,
               (sp_cyc_q.size() > NPIX) ? sp_cyc_q[NPIX] - sp_cyc_q[NPIX-1] : -1, PIX_PERIOD + 1);
    end
  endtask

  task automatic start_frame_with_mode(input int m);
    int found;
    found = 0;
    for (int i = 0; i < FRAME_PERIOD + 50 && found == 0; i++) begin
      @(negedge CLK);
      if (frame_begin === 1'b1) found = 1;
    end
    checks++;
    if (found == 0) begin
      errors++; $display("FAIL frame_begin_seen got 0 exp 1");
    end
    mode = m;
    byte_q.delete();
  endtask

  task automatic test_random();
    for (int i = 0; i < NPIX; i++) rand_lut[i] = 16'($urandom);
    start_frame_with_mode(1);
    check_frame_bytes("rand");
  endtask

  task automatic test_const();
    start_frame_with_mode(2);
    check_frame_bytes("const");
    checks++;
    if (sdin_viol != 0) begin
      errors++; $display("FAIL sdin_while_sclk_high got %0d exp 0", sdin_viol);
    end
    checks++;
    if (bad_runs != 0) begin
      errors++; $display("FAIL cs_low_runs got %0d bad exp 0", bad_runs);
    end
  endtask

  task automatic test_reset_mid();
    int found;
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      @(negedge CLK);
      if (sample_pixel === 1'b1) found = 1;
    end
    repeat (10) @(negedge CLK);
    checks++;
    if (found == 0 || cs !== 1'b0 || d_cn !== 1'b1 || sclk !== 1'b0) begin
      errors++;
      $display("FAIL mid_byte_pre got cs %b d_cn %b sclk %b exp 0 1 0", cs, d_cn, sclk);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({cs, sclk, sdin, d_cn, resn, vccen, pmoden, frame_begin, sending_pixels, sample_pixel}
        !== 10'b1100000000) begin
      errors++;
      $display("FAIL async_reset_pins got %b exp 1100000000",
               {cs, sclk, sdin, d_cn, resn, vccen, pmoden, frame_begin, sending_pixels, sample_pixel});
    end
    checks++;
    if (pixel_index !== 13'd0) begin
      errors++; $display("FAIL async_reset_index got %0d exp 0", pixel_index);
    end
    repeat (3) @(negedge CLK);
    test_power_seq();
    test_init();
  endtask

  initial begin
    test_reset();
    test_power_seq();
    test_init();
    test_ramp();
    test_frame_wrap();
    test_random();
    test_const();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
